ks_pipe_apx_adder: RTL and testbench

Pipelined, parametrised Kogge-Stone parallel-prefix adder with a per-transaction exact/approximate mode and valid/ready flow control. It generalises the combinational Kogge-Stone adder to any power-of-two width and a configurable pipeline depth. It adds a lower-part-OR (LOA) approximate mode on the APX_K least-significant bits. It sits between operand producers and result consumers in the AxPPA evaluation datapath and accepts one addition per cycle.

---
 rtl/ks_pipe_apx_adder_pkg.sv | 32 +++
 rtl/ks_pipe_apx_adder_prefix_level.sv | 33 +++
 rtl/ks_pipe_apx_adder.sv | 154 +++++++++++++++
 tb/tb_ks_pipe_apx_adder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pipe_apx_adder_pkg.sv
// -----------------------------------------------------------------------------
// ks_adder_pkg
// Shared definitions for the pipelined Kogge-Stone adder:
//   MODE_EXACT / MODE_APX : encoding of the per-transaction apx_mode input
//   clog2()               : ceiling log2, usable in constant expressions
//   n_stages()            : number of prefix pipeline banks for a width and
//                           a levels-per-bank setting
// -----------------------------------------------------------------------------
package ks_adder_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_APX   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Banks needed to hold all log2(width) prefix levels, lvl_per_stg per bank;
  // the last bank takes whatever levels remain.
  function automatic int n_stages(input int width, input int lvl_per_stg);
    return (clog2(width) + lvl_per_stg - 1) / lvl_per_stg;
  endfunction

endpackage

// File: rtl/ks_pipe_apx_adder_prefix_level.sv
// -----------------------------------------------------------------------------
// ks_prefix_level
// One combinational Kogge-Stone level. Bit i combines with bit i-2^LVL:
//   bits >= span : black cell (group generate and group propagate)
//   bits <  span : pass-through; their group generate is already complete.
// Ports:
//   g_i, p_i : group generate / propagate entering this level
//   g_o, p_o : group generate / propagate leaving this level
// -----------------------------------------------------------------------------
module ks_prefix_level
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LVL   = 0
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int SPAN = 1 << LVL;

  always_comb begin
    g_o = g_i;
    p_o = p_i;
    for (int i = SPAN; i < WIDTH; i++) begin
      g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      p_o[i] = p_i[i] & p_i[i-SPAN];
    end
  end

endmodule

// File: rtl/ks_pipe_apx_adder.sv
// -----------------------------------------------------------------------------
// ks_pipe_apx_adder
// Pipelined Kogge-Stone adder with per-transaction exact / lower-part-OR
// approximate mode and a global-stall valid/ready handshake.
// Latency is n_stages()+1 cycles; one result per cycle while out_ready = 1.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = ~out_valid | out_ready)
//   A, B, Cin           : operands and carry-in
//   apx_mode            : MODE_EXACT or MODE_APX, travels with its operands
//   out_valid/out_ready : result handshake
//   Sum                 : {carry-out, sum}, WIDTH+1 bits
//   Cout                : copy of Sum[WIDTH]
// -----------------------------------------------------------------------------
module ks_pipe_apx_adder
  import ks_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APX_K       = 4,
  parameter int LVL_PER_STG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             apx_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Sum,
  output logic             Cout
);

  localparam int LOG2W = clog2(WIDTH);
  localparam int N_STG = n_stages(WIDTH, LVL_PER_STG);

  // Bank s (0..N_STG-1) feeds prefix level s*LVL_PER_STG; the output
  // register is the final bank.
  logic [N_STG-1:0][WIDTH-1:0] g_d,  g_q;   // group generate
  logic [N_STG-1:0][WIDTH-1:0] p_d,  p_q;   // group propagate
  logic [N_STG-1:0][WIDTH-1:0] pb_d, pb_q;  // per-bit propagate for the sum XOR
  logic [N_STG-1:0]            cin_d, cin_q;
  logic [N_STG-1:0]            vld_d, vld_q;

  logic [LOG2W-1:0][WIDTH-1:0] lin_g, lin_p, lvl_g;
  logic [LOG2W-2:0][WIDTH-1:0] lvl_p;
  logic [WIDTH-1:0]            unused_p_last;

  logic [WIDTH-1:0] pb_in, g_in, g_fin;
  logic             cin_in;
  logic [WIDTH:0]   sum_d, sum_q;
  logic             out_vld_q;
  logic             advance;

  // Single stall signal: every bank moves together or holds together.
  assign advance  = ~out_vld_q | out_ready;
  assign in_ready = advance;

  // ---- operand preparation, feeding bank 0 ----
  // Approximate mode folds the LOA into the prefix inputs: the low bits
  // propagate A|B with no generate (so their sum bits become A|B and no
  // carry ripples among them), except bit APX_K-1 keeps A&B, which becomes
  // exactly the carry injected into bit APX_K. Cin is dropped. Exact mode
  // folds Cin into the bit-0 generate so the prefix tree yields true carries.
  always_comb begin
    pb_in  = A ^ B;
    g_in   = A & B;
    cin_in = Cin;
    if ((apx_mode == MODE_APX) && (APX_K > 0)) begin
      for (int i = 0; i < APX_K; i++) begin
        pb_in[i] = A[i] | B[i];
        if (i < APX_K - 1) begin
          g_in[i] = 1'b0;
        end
      end
      cin_in = 1'b0;
    end
    g_in[0] = g_in[0] | (pb_in[0] & cin_in);
  end

  assign g_d[0]   = g_in;
  assign p_d[0]   = pb_in;
  assign pb_d[0]  = pb_in;
  assign cin_d[0] = cin_in;
  assign vld_d[0] = in_valid;

  // ---- prefix levels, with a bank boundary every LVL_PER_STG levels ----
  for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
    if ((l % LVL_PER_STG) == 0) begin : g_from_bank
      assign lin_g[l] = g_q[l / LVL_PER_STG];
      assign lin_p[l] = p_q[l / LVL_PER_STG];
    end else begin : g_from_lvl
      assign lin_g[l] = lvl_g[l-1];
      assign lin_p[l] = lvl_p[l-1];
    end

    if (l == LOG2W - 1) begin : g_last
      ks_prefix_level #(.WIDTH(WIDTH), .LVL(l)) u_lvl (
        .g_i (lin_g[l]),
        .p_i (lin_p[l]),
        .g_o (lvl_g[l]),
        .p_o (unused_p_last)
      );
    end else begin : g_mid
      ks_prefix_level #(.WIDTH(WIDTH), .LVL(l)) u_lvl (
        .g_i (lin_g[l]),
        .p_i (lin_p[l]),
        .g_o (lvl_g[l]),
        .p_o (lvl_p[l])
      );
    end
  end

  // ---- banks 1..N_STG-1: capture level outputs, forward side-band ----
  for (genvar s = 1; s < N_STG; s++) begin : g_bank
    assign g_d[s]   = lvl_g[s*LVL_PER_STG-1];
    assign p_d[s]   = lvl_p[s*LVL_PER_STG-1];
    assign pb_d[s]  = pb_q[s-1];
    assign cin_d[s] = cin_q[s-1];
    assign vld_d[s] = vld_q[s-1];
  end

  // ---- final bank: carries to sum ----
  // g_fin[i] is the carry out of bit i; the carry into bit 0 is Cin.
  assign g_fin = lvl_g[LOG2W-1];
  assign sum_d = {g_fin[WIDTH-1], pb_q[N_STG-1] ^ {g_fin[WIDTH-2:0], cin_q[N_STG-1]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q       <= '0;
      p_q       <= '0;
      pb_q      <= '0;
      cin_q     <= '0;
      vld_q     <= '0;
      sum_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (advance) begin
      g_q       <= g_d;
      p_q       <= p_d;
      pb_q      <= pb_d;
      cin_q     <= cin_d;
      vld_q     <= vld_d;
      sum_q     <= sum_d;
      out_vld_q <= vld_q[N_STG-1];
    end
  end

  assign out_valid = out_vld_q;
  assign Sum       = sum_q;
  assign Cout      = sum_q[WIDTH];

endmodule

// File: tb/tb_ks_pipe_apx_adder.sv
// -----------------------------------------------------------------------------
// tb_ks_pipe_apx_adder
// Self-checking bench for ks_pipe_apx_adder at default parameters
// (WIDTH=16, APX_K=4, LVL_PER_STG=1, latency 5). Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ks_pipe_apx_adder;

  localparam int W   = 16;
  localparam int K   = 4;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         apx_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   Sum;
  logic         Cout;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  ks_pipe_apx_adder #(.WIDTH(W), .APX_K(K), .LVL_PER_STG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .apx_mode  (apx_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  // Golden model: exact add, or LOA on the K low bits with carry A[K-1]&B[K-1].
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic mode);
    logic [W-K:0] hi;
    logic         c;
    if (!mode) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    c  = a[K-1] & b[K-1];
    hi = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]} + {{(W-K){1'b0}}, c};
    return {hi, a[K-1:0] | b[K-1:0]};
  endfunction

  // Drives one transaction and waits for its result (stimulus only).
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic mode, output logic [W:0] s, output logic c,
                          output int lat);
    @(negedge clk);
    A = a; B = b; Cin = cin; apx_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; s = 'x; c = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        s = Sum; c = Cout; lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else pass_cnt++;
    chk_cnt++; if (Sum !== '0) $display("FAIL reset_sum got=%h want=0", Sum); else pass_cnt++;
    chk_cnt++; if (Cout !== 1'b0) $display("FAIL reset_cout got=%b want=0", Cout); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_exact();
    logic [W:0] s; logic c; int lat;
    send_one(16'd5, 16'd7, 1'b1, 1'b0, s, c, lat);
    chk_cnt++; if (s !== 17'd13) $display("FAIL exact_5_7_1 got=%h want=%h", s, 17'd13); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL exact_5_7_1_cout got=%b want=0", c); else pass_cnt++;
    chk_cnt++; if (lat !== LAT) $display("FAIL exact_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
    send_one(16'hFFFF, 16'd1, 1'b0, 1'b0, s, c, lat);
    chk_cnt++; if (s !== 17'h10000) $display("FAIL exact_ffff_1 got=%h want=%h", s, 17'h10000); else pass_cnt++;
    chk_cnt++; if (c !== 1'b1) $display("FAIL exact_ffff_1_cout got=%b want=1", c); else pass_cnt++;
    chk_cnt++; if (lat !== LAT) $display("FAIL exact_ffff_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
  endtask

  task automatic test_apx();
    logic [W:0] s; logic c; int lat;
    send_one(16'hFFFF, 16'd1, 1'b0, 1'b1, s, c, lat);
    chk_cnt++; if (s !== 17'h0FFFF) $display("FAIL apx_ffff_1 got=%h want=%h", s, 17'h0FFFF); else pass_cnt++;
    chk_cnt++; if (c !== 1'b0) $display("FAIL apx_ffff_1_cout got=%b want=0", c); else pass_cnt++;
    send_one(16'h000F, 16'd1, 1'b0, 1'b1, s, c, lat);
    chk_cnt++; if (s !== 17'h0000F) $display("FAIL apx_000f_1 got=%h want=%h", s, 17'h0000F); else pass_cnt++;
    send_one(16'h0008, 16'h0008, 1'b0, 1'b1, s, c, lat);
    chk_cnt++; if (s !== 17'h00018) $display("FAIL apx_carry_inject got=%h want=%h", s, 17'h00018); else pass_cnt++;
    send_one(16'h0000, 16'h0000, 1'b1, 1'b1, s, c, lat);
    chk_cnt++; if (s !== 17'h00000) $display("FAIL apx_cin_ignored got=%h want=0", s); else pass_cnt++;
    chk_cnt++; if (lat !== LAT) $display("FAIL apx_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, gaps = 0, last = -1;
    logic [W:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL b2b_unexpected_output got=%h", Sum);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (Sum !== e) $display("FAIL b2b_result_%0d got=%h want=%h", got, Sum, e); else pass_cnt++;
        end
        if (last >= 0 && cyc != last + 1) gaps++;
        last = cyc;
        got++;
      end
      if (sent < 8) begin
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); apx_mode = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back(model(A, B, Cin, apx_mode));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk_cnt++; if (got !== 8) $display("FAIL b2b_count got=%0d want=8", got); else pass_cnt++;
    chk_cnt++; if (gaps !== 0) $display("FAIL b2b_gaps got=%0d want=0", gaps); else pass_cnt++;
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, stalled = 0;
    bit have_pend = 0;
    logic [W:0] held = 'x;
    logic [W:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 7 && cyc <= 9);
      #1;
      if (out_valid && !out_ready) begin
        stalled++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); else pass_cnt++;
        if (cyc == 7) held = Sum;
        else begin
          chk_cnt++; if (Sum !== held) $display("FAIL stall_sum_stable cyc=%0d got=%h want=%h", cyc, Sum, held); else pass_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL stall_unexpected_output got=%h", Sum);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (Sum !== e) $display("FAIL stall_result_%0d got=%h want=%h", got, Sum, e); else pass_cnt++;
        end
        got++;
      end
      if (sent < 8) begin
        if (!have_pend) begin
          A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); apx_mode = 1'($urandom_range(0, 1));
          have_pend = 1;
        end
        in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back(model(A, B, Cin, apx_mode));
          sent++;
          have_pend = 0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk_cnt++; if (stalled !== 3) $display("FAIL stall_cycles got=%0d want=3", stalled); else pass_cnt++;
    chk_cnt++; if (got !== 8) $display("FAIL stall_count got=%0d want=8", got); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL stall_leftover got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    logic [W:0] s; logic c; int lat;
    int spurious = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = W'(16'h1234 + i); B = W'(16'h0101 * (i + 1)); Cin = 1'b1; apx_mode = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b want=0", out_valid); else pass_cnt++;
    chk_cnt++; if (Sum !== '0) $display("FAIL midrst_sum got=%h want=0", Sum); else pass_cnt++;
    chk_cnt++; if (Cout !== 1'b0) $display("FAIL midrst_cout got=%b want=0", Cout); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk_cnt++; if (spurious !== 0) $display("FAIL midrst_flushed got=%0d want=0", spurious); else pass_cnt++;
    send_one(16'd1, 16'd10, 1'b0, 1'b0, s, c, lat);
    chk_cnt++; if (s !== 17'd11) $display("FAIL midrst_new_op got=%h want=%h", s, 17'd11); else pass_cnt++;
    chk_cnt++; if (lat !== LAT) $display("FAIL midrst_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_apx();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
